// File: rtl/a2d_pkg.sv
// Shared types and helpers for the A2D scan controller.
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        ADDR,
        WAIT_A,
        READ,
        WAIT_R,
        STORE
    } a2d_state_t;

    localparam int CMD_CH_LSB = 11;
    localparam int RES_W      = 12;
    localparam int CMD_W      = 16;

    // ADC128S command word: channel address in bits [13:11], all else zero.
    function automatic logic [CMD_W-1:0] a2d_cmd(input logic [2:0] ch);
        logic [CMD_W-1:0] c;
        c = '0;
        c[CMD_CH_LSB +: 3] = ch;
        return c;
    endfunction

    // Lowest set bit of a channel mask; zero when the mask is empty.
    function automatic logic [2:0] a2d_first_ch(input logic [7:0] mask);
        logic [2:0] f;
        f = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) f = 3'(i);
        end
        return f;
    endfunction

endpackage

// File: rtl/a2d_next_ch.sv
// Round-robin next-set-bit finder for the scan pointer.
module a2d_next_ch (
    input  logic [7:0] mask,
    input  logic [2:0] cur_ch,
    output logic [2:0] nxt_ch,
    output logic       wrapped
);

    logic [2:0] low_ch;

    // Pick the nearest set bit above cur_ch; fall back to the lowest set bit.
    always_comb begin
        nxt_ch  = '0;
        low_ch  = '0;
        wrapped = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) low_ch = 3'(i);
            if (mask[i] && (i > int'(cur_ch))) begin
                nxt_ch  = 3'(i);
                wrapped = 1'b0;
            end
        end
        if (wrapped) nxt_ch = low_ch;
    end

endmodule

// File: rtl/a2d_scan_ctrl.sv
// A2D sequencing controller: round-robin channel scan plus priority
// one-shot host conversions, driving a 16-bit SPI master.
module a2d_scan_ctrl
    import a2d_pkg::*;
#(
    parameter int         NUM_CH  = 8,
    parameter logic [7:0] CH_MASK = 8'hFF,
    parameter int         GAP_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req,
    input  logic [2:0]        req_ch,
    output logic              req_ack,
    output logic              req_vld,
    output logic [RES_W-1:0]  req_data,
    output logic              wrt,
    output logic [CMD_W-1:0]  cmd,
    input  logic              done,
    input  logic [CMD_W-1:0]  rd_data,
    input  logic [2:0]        rd_ch,
    output logic [RES_W-1:0]  rd_res,
    output logic [NUM_CH-1:0] res_vld,
    output logic              new_data,
    output logic              sweep_done
);

    localparam logic [7:0]  NUM_MASK  = 8'((1 << NUM_CH) - 1);
    localparam logic [7:0]  SCAN_MASK = CH_MASK & NUM_MASK;
    localparam logic [2:0]  FIRST_CH  = a2d_first_ch(SCAN_MASK);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);

    a2d_state_t       state;
    logic [2:0]       scan_ptr;
    logic [2:0]       conv_ch;
    logic             conv_host;
    logic [15:0]      gap_cnt;
    logic [RES_W-1:0] res_mem [8];
    logic [7:0]       vld_all;
    logic [2:0]       nxt_ch;
    logic             wrapped;
    logic             ch_in_range;
    logic             unused_rd_hi;

    assign ch_in_range  = int'(conv_ch) < NUM_CH;
    assign unused_rd_hi = ^rd_data[CMD_W-1:RES_W];

    a2d_next_ch u_next_ch (
        .mask    (SCAN_MASK),
        .cur_ch  (scan_ptr),
        .nxt_ch  (nxt_ch),
        .wrapped (wrapped)
    );

    // Result readback is a plain mux; out-of-range addresses read zero.
    assign rd_res  = (int'(rd_ch) < NUM_CH) ? res_mem[rd_ch] : '0;
    assign res_vld = vld_all[NUM_CH-1:0];

    // Conversion sequencer: arbitration in IDLE, two SPI transactions, store, gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            scan_ptr   <= FIRST_CH;
            conv_ch    <= '0;
            conv_host  <= 1'b0;
            gap_cnt    <= '0;
            wrt        <= 1'b0;
            cmd        <= '0;
            req_ack    <= 1'b0;
            req_vld    <= 1'b0;
            req_data   <= '0;
            new_data   <= 1'b0;
            sweep_done <= 1'b0;
            vld_all    <= '0;
            for (int i = 0; i < 8; i++) res_mem[i] <= '0;
        end else begin
            wrt        <= 1'b0;
            req_ack    <= 1'b0;
            req_vld    <= 1'b0;
            new_data   <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        conv_host <= 1'b1;
                        conv_ch   <= req_ch;
                        cmd       <= a2d_cmd(req_ch);
                        req_ack   <= 1'b1;
                        wrt       <= 1'b1;
                        state     <= ADDR;
                    end else if (en && (SCAN_MASK != 8'h00)) begin
                        conv_host <= 1'b0;
                        conv_ch   <= scan_ptr;
                        cmd       <= a2d_cmd(scan_ptr);
                        wrt       <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: state <= WAIT_A;
                WAIT_A: begin
                    if (done) begin
                        wrt   <= 1'b1;
                        state <= READ;
                    end
                end
                READ: state <= WAIT_R;
                WAIT_R: begin
                    if (done) state <= STORE;
                end
                STORE: begin
                    if (ch_in_range) begin
                        res_mem[conv_ch] <= rd_data[RES_W-1:0];
                        vld_all[conv_ch] <= 1'b1;
                        new_data         <= 1'b1;
                    end
                    if (conv_host) begin
                        req_data <= rd_data[RES_W-1:0];
                        req_vld  <= 1'b1;
                    end else begin
                        scan_ptr   <= nxt_ch;
                        sweep_done <= wrapped;
                    end
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) state <= IDLE;
                    else gap_cnt <= gap_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Directed bench for a2d_scan_ctrl with behavioural SPI slave stubs.
module tb_a2d_scan_ctrl;

    // Stub done rises 4 cycles after wrt, so a host conversion spans
    // ADDR(1) + WAIT_A(4) + READ(1) + WAIT_R(4) + STORE(1) = 11 cycles ack->vld.
    localparam int LAT      = 3;
    localparam int GAP_A    = 4;
    localparam int HOST_LAT = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, req, wrt, req_ack, req_vld, new_data, sweep_done, done_a, force_done;
    logic [2:0]  req_ch, rd_ch;
    logic [11:0] req_data, rd_res;
    logic [15:0] cmd, rd_data_a;
    logic [7:0]  res_vld;

    logic        rst_b, en_b, req_b, wrt_b, req_ack_b, req_vld_b, new_data_b, sweep_done_b, done_b;
    logic [2:0]  req_ch_b, rd_ch_b;
    logic [11:0] req_data_b, rd_res_b;
    logic [15:0] cmd_b, rd_data_b;
    logic [3:0]  res_vld_b;

    int checks;
    int errors;

    a2d_scan_ctrl #(.NUM_CH(8), .CH_MASK(8'hA5), .GAP_CYC(GAP_A)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .req_ch(req_ch),
        .req_ack(req_ack), .req_vld(req_vld), .req_data(req_data),
        .wrt(wrt), .cmd(cmd), .done(done_a), .rd_data(rd_data_a),
        .rd_ch(rd_ch), .rd_res(rd_res), .res_vld(res_vld),
        .new_data(new_data), .sweep_done(sweep_done)
    );

    a2d_scan_ctrl #(.NUM_CH(4), .CH_MASK(8'h01), .GAP_CYC(GAP_A)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .req(req_b), .req_ch(req_ch_b),
        .req_ack(req_ack_b), .req_vld(req_vld_b), .req_data(req_data_b),
        .wrt(wrt_b), .cmd(cmd_b), .done(done_b), .rd_data(rd_data_b),
        .rd_ch(rd_ch_b), .rd_res(rd_res_b), .res_vld(res_vld_b),
        .new_data(new_data_b), .sweep_done(sweep_done_b)
    );

    // Stub slave A: returns the addressed channel number as the result.
    logic       stub_done_a;
    logic [2:0] lat_ch_a;
    int         cnt_a;
    always @(posedge clk) begin
        if (rst) begin
            stub_done_a <= 1'b0;
            cnt_a       <= 0;
            rd_data_a   <= '0;
            lat_ch_a    <= '0;
        end else if (wrt) begin
            stub_done_a <= 1'b0;
            cnt_a       <= LAT;
            lat_ch_a    <= cmd[13:11];
        end else if (cnt_a != 0) begin
            if (cnt_a == 1) begin
                stub_done_a <= 1'b1;
                rd_data_a   <= {13'h0, lat_ch_a};
            end
            cnt_a <= cnt_a - 1;
        end
    end
    assign done_a = stub_done_a | force_done;

    // Stub slave B: mimics a falling ADC reading, 12'hC00 then -0x10 per conversion.
    int cnt_b;
    int xact_b;
    always @(posedge clk) begin
        if (rst_b) begin
            done_b    <= 1'b0;
            cnt_b     <= 0;
            xact_b    <= 0;
            rd_data_b <= '0;
        end else if (wrt_b) begin
            done_b <= 1'b0;
            cnt_b  <= LAT;
        end else if (cnt_b != 0) begin
            if (cnt_b == 1) begin
                done_b    <= 1'b1;
                rd_data_b <= 16'(12'hC00 - 12'(16 * (xact_b / 2)));
                xact_b    <= xact_b + 1;
            end
            cnt_b <= cnt_b - 1;
        end
    end

    // Observers: log every store with the channel the stub last saw, count wrt pulses.
    logic [2:0]  store_ch_q[$];
    logic        sweep_q[$];
    logic [11:0] b_vals[$];
    logic        b_sweeps[$];
    int          wrt_cnt = 0;
    always @(negedge clk) begin
        if (wrt) wrt_cnt <= wrt_cnt + 1;
        if (new_data) begin
            store_ch_q.push_back(lat_ch_a);
            sweep_q.push_back(sweep_done);
        end
        if (new_data_b) begin
            b_vals.push_back(rd_res_b);
            b_sweeps.push_back(sweep_done_b);
        end
    end

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] exp_res;
        logic        exp_vld;
    } rd_vec_t;

    typedef struct {
        logic [2:0] ch;
        logic       sweep;
    } order_vec_t;

    rd_vec_t    rd_tbl [8];
    order_vec_t ord_tbl [5];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en_v, input logic req_v, input logic [2:0] req_ch_v);
        en     = en_v;
        req    = req_v;
        req_ch = req_ch_v;
    endtask

    task automatic wait_signal(input string name, input int sel, input int budget, output int n);
        bit hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < budget) begin
            tick(1);
            n++;
            case (sel)
                0:       hit = wrt;
                1:       hit = req_ack;
                2:       hit = req_vld;
                3:       hit = req_ack_b;
                default: hit = req_vld_b;
            endcase
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: no event after %0d cycles, expected one within %0d", name, n, budget);
        end
    endtask

    task automatic wait_stores(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (store_ch_q.size() < target && n < budget) begin
            tick(1);
            n++;
        end
        if (store_ch_q.size() < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got %0d stores, expected %0d", name, store_ch_q.size(), target);
        end
    endtask

    task automatic wait_stores_b(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (b_vals.size() < target && n < budget) begin
            tick(1);
            n++;
        end
        if (b_vals.size() < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got %0d stores, expected %0d", name, b_vals.size(), target);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " wrt"},        32'(wrt),        32'h0);
        checkOutput({tag, " cmd"},        32'(cmd),        32'h0);
        checkOutput({tag, " req_ack"},    32'(req_ack),    32'h0);
        checkOutput({tag, " req_vld"},    32'(req_vld),    32'h0);
        checkOutput({tag, " req_data"},   32'(req_data),   32'h0);
        checkOutput({tag, " new_data"},   32'(new_data),   32'h0);
        checkOutput({tag, " sweep_done"}, 32'(sweep_done), 32'h0);
        checkOutput({tag, " res_vld"},    32'(res_vld),    32'h0);
        checkOutput({tag, " rd_res"},     32'(rd_res),     32'h0);
    endtask

    // Main directed sequence.
    initial begin
        int n, s0, w0;
        checks = 0;
        errors = 0;
        rst = 1'b1; rst_b = 1'b1; force_done = 1'b0; rd_ch = 3'd0;
        applyStimulus(1'b0, 1'b0, 3'd0);
        en_b = 1'b0; req_b = 1'b0; req_ch_b = 3'd0; rd_ch_b = 3'd0;

        rd_tbl[0] = '{3'd0, 12'h000, 1'b1};
        rd_tbl[1] = '{3'd1, 12'h000, 1'b0};
        rd_tbl[2] = '{3'd2, 12'h002, 1'b1};
        rd_tbl[3] = '{3'd3, 12'h000, 1'b0};
        rd_tbl[4] = '{3'd4, 12'h000, 1'b0};
        rd_tbl[5] = '{3'd5, 12'h005, 1'b1};
        rd_tbl[6] = '{3'd6, 12'h000, 1'b0};
        rd_tbl[7] = '{3'd7, 12'h007, 1'b1};
        ord_tbl[0] = '{3'd0, 1'b0};
        ord_tbl[1] = '{3'd2, 1'b0};
        ord_tbl[2] = '{3'd5, 1'b0};
        ord_tbl[3] = '{3'd7, 1'b1};
        ord_tbl[4] = '{3'd0, 1'b0};

        tick(3);
        check_all_zero("reset");
        checkOutput("reset b res_vld", 32'(res_vld_b), 32'h0);
        checkOutput("reset b wrt", 32'(wrt_b), 32'h0);
        rst = 1'b0; rst_b = 1'b0;
        tick(5);
        checkOutput("idle without en", 32'(wrt_cnt), 32'd0);

        // Single-channel scan on instance B.
        en_b = 1'b1;
        wait_stores_b("b scan stores", 2, 200);
        en_b = 1'b0;
        checkOutput("b first result", 32'(b_vals[0]), 32'hC00);
        checkOutput("b second result", 32'(b_vals[1]), 32'hBF0);
        checkOutput("b sweep 0", 32'(b_sweeps[0]), 32'h1);
        checkOutput("b sweep 1", 32'(b_sweeps[1]), 32'h1);
        tick(30);
        // Host request to an out-of-range channel on the 4-channel instance.
        req_b = 1'b1; req_ch_b = 3'd6;
        wait_signal("b host ack", 3, 100, n);
        checkOutput("b host cmd", 32'(cmd_b), 32'h3000);
        req_b = 1'b0;
        wait_signal("b host vld", 4, 100, n);
        checkOutput("b host req_data", 32'(req_data_b), 32'hBE0);
        tick(10);
        checkOutput("b res_vld untouched", 32'(res_vld_b), 32'h1);
        checkOutput("b no store for ch6", 32'(b_vals.size()), 32'd2);
        checkOutput("b ch0 result kept", 32'(rd_res_b), 32'hBF0);
        rd_ch_b = 3'd6;
        #1;
        checkOutput("b rd out of range", 32'(rd_res_b), 32'h0);

        // Scan over mask A5 on instance A.
        applyStimulus(1'b1, 1'b0, 3'd0);
        wait_stores("a scan stores", 5, 400);
        applyStimulus(1'b0, 1'b0, 3'd0);
        tick(50);
        checkOutput("a store count", 32'(store_ch_q.size()), 32'd5);
        checkOutput("a wrt count", 32'(wrt_cnt), 32'd10);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("order ch[%0d]", i), 32'(store_ch_q[i]), 32'(ord_tbl[i].ch));
            checkOutput($sformatf("order sweep[%0d]", i), 32'(sweep_q[i]), 32'(ord_tbl[i].sweep));
        end
        for (int i = 0; i < 8; i++) begin
            rd_ch = rd_tbl[i].ch;
            #1;
            checkOutput($sformatf("rd_res[%0d]", i), 32'(rd_res), 32'(rd_tbl[i].exp_res));
            checkOutput($sformatf("res_vld[%0d]", i), 32'(res_vld[rd_tbl[i].ch]), 32'(rd_tbl[i].exp_vld));
        end

        // Host request raised while the ch2 scan conversion is in flight.
        applyStimulus(1'b1, 1'b0, 3'd0);
        wait_signal("scan addr wrt", 0, 100, n);
        s0 = store_ch_q.size();
        applyStimulus(1'b1, 1'b1, 3'd3);
        wait_signal("host ack", 1, 100, n);
        checkOutput("ack after in-flight store", 32'(store_ch_q.size()), 32'(s0 + 1));
        checkOutput("host cmd", 32'(cmd), 32'h1800);
        checkOutput("host wrt with ack", 32'(wrt), 32'h1);
        applyStimulus(1'b1, 1'b0, 3'd3);
        tick(1);
        checkOutput("ack one cycle", 32'(req_ack), 32'h0);
        wait_signal("host vld", 2, 100, n);
        checkOutput("host latency", 32'(n + 1), 32'(HOST_LAT));
        checkOutput("host req_data", 32'(req_data), 32'h003);
        wait_stores("post-host stores", s0 + 3, 100);
        applyStimulus(1'b0, 1'b0, 3'd0);
        checkOutput("in-flight ch", 32'(store_ch_q[s0]), 32'd2);
        checkOutput("host store ch", 32'(store_ch_q[s0 + 1]), 32'd3);
        checkOutput("scan resume ch", 32'(store_ch_q[s0 + 2]), 32'd5);
        tick(50);
        checkOutput("res_vld after host", 32'(res_vld), 32'hAD);
        rd_ch = 3'd3;
        #1;
        checkOutput("rd_res host ch", 32'(rd_res), 32'h003);

        // en dropped during WAIT_A: conversion still completes, then idle.
        s0 = store_ch_q.size();
        w0 = wrt_cnt;
        applyStimulus(1'b1, 1'b0, 3'd0);
        wait_signal("en-drop addr", 0, 100, n);
        tick(1);
        applyStimulus(1'b0, 1'b0, 3'd0);
        tick(60);
        checkOutput("en-drop stores", 32'(store_ch_q.size()), 32'(s0 + 1));
        checkOutput("en-drop wrt", 32'(wrt_cnt), 32'(w0 + 2));
        checkOutput("en-drop ch", 32'(store_ch_q[s0]), 32'd7);

        // done held high across both waits.
        s0 = store_ch_q.size();
        w0 = wrt_cnt;
        applyStimulus(1'b1, 1'b0, 3'd0);
        wait_signal("held-done addr", 0, 100, n);
        force_done = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0);
        tick(5);
        force_done = 1'b0;
        tick(40);
        checkOutput("held-done wrt", 32'(wrt_cnt), 32'(w0 + 2));
        checkOutput("held-done stores", 32'(store_ch_q.size()), 32'(s0 + 1));

        // Reset asserted in WAIT_R.
        applyStimulus(1'b1, 1'b0, 3'd0);
        wait_signal("rst addr", 0, 100, n);
        wait_signal("rst read", 0, 100, n);
        tick(1);
        s0 = store_ch_q.size();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0);
        rd_ch = 3'd3;
        tick(1);
        check_all_zero("mid rst");
        tick(2);
        rst = 1'b0;
        tick(20);
        checkOutput("rst no store", 32'(store_ch_q.size()), 32'(s0));
        applyStimulus(1'b1, 1'b0, 3'd0);
        wait_stores("post-rst store", s0 + 1, 100);
        applyStimulus(1'b0, 1'b0, 3'd0);
        checkOutput("post-rst first ch", 32'(store_ch_q[s0]), 32'd0);
        tick(30);
        checkOutput("post-rst res_vld", 32'(res_vld), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a bounded wait is somehow bypassed.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
